vend_ctrl: RTL
==============

# vend_ctrl

Transaction controller for the vending machine datapath. Accumulates coin credit, walks a product-selection cursor over five fixed prices, and sequences a purchase through a dispense handshake. Returns remaining credit as a coin-by-coin change handshake on cancel. Sits between the debounced button/coin front end and the display/LED datapath, which reads `credit`, `sel_idx`, `sel_price` and `affordable`.

## Interface
- `PRICE0`..`PRICE4`, 7 / 5 / 6 / 10 / 8: product prices in credit units, 4 bits each.
- `MAX_CREDIT`, 99: highest credit held. A coin that would exceed it is rejected.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `coin_valid` input 1: one-cycle coin-insert pulse.
- `coin_value` input 2: 00=1, 01=5, 10=10, 11=20 units.
- `sel_left`, `sel_right` input 1 each: one-cycle cursor-move pulses.
- `buy` input 1: one-cycle purchase request.
- `cancel` input 1: one-cycle refund request.
- `dispense_ack` input 1: dispenser accepted the item.
- `change_ack` input 1: payout unit accepted the current coin.
- `credit` output 7: current credit, registered.
- `sel_idx` output 3: cursor position, 0..4, registered.
- `sel_price` output 4: `PRICE[sel_idx]`, combinational.
- `affordable` output 5: bit i = (`credit` >= `PRICEi`), combinational.
- `dispense_req` output 1: item dispense request.
- `dispense_idx` output 3: product being dispensed, latched at buy.
- `change_req` output 1: coin payout request.
- `change_coin` output 2: coin to pay, same encoding as `coin_value`.
- `coin_reject` output 1: one-cycle pulse; coin not credited.
- `buy_denied` output 1: one-cycle pulse; credit was below price.
- `busy` output 1: high when state is not IDLE.

## Operation
- States:
  - IDLE: the only state that accepts coin, select, buy or cancel.
  - VEND: `dispense_req` is held.
  - CHANGE: payout in progress.
  - GAP: one-cycle spacer between payout coins.
- Reset values: state IDLE; `credit` 0; `sel_idx` 0; `dispense_idx` 0; `dispense_req`, `change_req`, `coin_reject`, `buy_denied` all 0; `change_coin` 00.
- IDLE event priority, one event per cycle: cancel > buy > coin > select.
  - A `coin_valid` that loses arbitration is rejected (`coin_reject` pulses).
  - Losing select pulses are dropped.
- Coin: if `credit + value` <= `MAX_CREDIT`, add the value to `credit`; otherwise pulse `coin_reject` and leave `credit` unchanged. Use an 8-bit sum internally so no wrap occurs.
- Coin in VEND, CHANGE or GAP: pulse `coin_reject`.
- Select: `sel_right` increments `sel_idx`, wrapping 4 to 0. `sel_left` decrements, wrapping 0 to 4. Both high in the same cycle: no move.
- Buy:
  - If `credit` >= `sel_price`: `credit` -= `sel_price`, `dispense_idx` <= `sel_idx`, `dispense_req` <= 1, go to VEND.
  - Otherwise pulse `buy_denied` and stay in IDLE.
- VEND: hold `dispense_req` until `dispense_ack` is sampled high while `dispense_req` is high. Then `dispense_req` <= 0 and go to IDLE. Remaining credit is retained.
- Cancel with `credit` = 0: no-op.
- Cancel with `credit` > 0: go to CHANGE.
- CHANGE: `change_coin` is the largest denomination <= `credit` (20, 10, 5, 1); `change_req` = 1.
  - On `change_ack` with `change_req` high: `credit` -= coin value and `change_req` <= 0.
  - If the new credit is 0, go to IDLE; otherwise go to GAP.
- GAP: `change_req` = 0 for one cycle, then return to CHANGE.
- `dispense_ack` outside VEND and `change_ack` outside CHANGE are ignored.
- `rst` in any state returns to reset values at the next edge. Credit in flight is discarded, and no request is left asserted.

## Timing
- All outputs except `sel_price` and `affordable` are registered.
- Coin, select and buy take effect on the edge that samples the pulse; results are visible the following cycle.
- `dispense_req` rises on the edge after `buy`.
- Ack in cycle N drops `dispense_req` and returns to IDLE at edge N; a new buy is accepted from cycle N+1.
- Change payout: the first `change_req` is visible the cycle after `cancel`. Minimum 2 cycles per coin (CHANGE + GAP) when the ack is immediate.
- `coin_reject` and `buy_denied` are high exactly one cycle, the cycle after the offending pulse.

## Test plan
- Coins, then buy: reset, coins 5, 1, 1 → `credit`=7, `affordable`=5'b00111. `buy` at `sel_idx`=0 → `credit`=0, `dispense_req`=1, `dispense_idx`=0. `dispense_ack` → `dispense_req`=0, `busy`=0.
- Denied buy: `credit`=5 with `sel_right` ×3 → `sel_idx`=3, `sel_price`=10. `buy` → `buy_denied` one-cycle pulse, `credit` stays 5, state stays IDLE.
- Change: `credit`=37, `cancel`, immediate acks → `change_coin` sequence 11, 10, 01, 00, 00 with `change_req` low between coins. Ends with `credit`=0, IDLE.
- Overflow and busy reject: `credit`=90, coin 20 → `coin_reject`, `credit`=90. Coin 1 during VEND → `coin_reject`, `credit` unchanged.
- Wrap and simultaneous events: `sel_left` at 0 → 4; `sel_right` at 4 → 0; both together → no move. `buy` + `coin_valid` in the same cycle → buy handled, `coin_reject` pulses.
- Reset mid-operation: `rst` during CHANGE with `change_req` high → next cycle `change_req`=0, `credit`=0, `sel_idx`=0, `busy`=0.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending machine transaction controller: coin credit, product cursor,
// dispense handshake and coin-by-coin change payout on cancel.
module vend_ctrl #(
  parameter logic [3:0] PRICE0     = 4'd7,
  parameter logic [3:0] PRICE1     = 4'd5,
  parameter logic [3:0] PRICE2     = 4'd6,
  parameter logic [3:0] PRICE3     = 4'd10,
  parameter logic [3:0] PRICE4     = 4'd8,
  parameter logic [6:0] MAX_CREDIT = 7'd99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_left,
  input  logic       sel_right,
  input  logic       buy,
  input  logic       cancel,
  input  logic       dispense_ack,
  input  logic       change_ack,
  output logic [6:0] credit,
  output logic [2:0] sel_idx,
  output logic [3:0] sel_price,
  output logic [4:0] affordable,
  output logic       dispense_req,
  output logic [2:0] dispense_idx,
  output logic       change_req,
  output logic [1:0] change_coin,
  output logic       coin_reject,
  output logic       buy_denied,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, GAP} state_t;

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [2:0] sel_idx_q, sel_idx_d;
  logic [2:0] dispense_idx_q, dispense_idx_d;
  logic       dispense_req_q, dispense_req_d;
  logic       change_req_q, change_req_d;
  logic [1:0] change_coin_q, change_coin_d;
  logic       coin_reject_q, coin_reject_d;
  logic       buy_denied_q, buy_denied_d;

  logic [7:0] coin_sum;

  // Coin encoding to credit units.
  function automatic logic [4:0] coin_units(input logic [1:0] code);
    case (code)
      2'b00:   coin_units = 5'd1;
      2'b01:   coin_units = 5'd5;
      2'b10:   coin_units = 5'd10;
      default: coin_units = 5'd20;
    endcase
  endfunction

  // Largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] payout_coin(input logic [6:0] cr);
    if (cr >= 7'd20)      payout_coin = 2'b11;
    else if (cr >= 7'd10) payout_coin = 2'b10;
    else if (cr >= 7'd5)  payout_coin = 2'b01;
    else                  payout_coin = 2'b00;
  endfunction

  // Price lookup for the cursor position.
  always_comb begin
    case (sel_idx_q)
      3'd1:    sel_price = PRICE1;
      3'd2:    sel_price = PRICE2;
      3'd3:    sel_price = PRICE3;
      3'd4:    sel_price = PRICE4;
      default: sel_price = PRICE0;
    endcase
  end

  // Affordability flags for the display.
  always_comb begin
    affordable[0] = credit_q >= {3'b000, PRICE0};
    affordable[1] = credit_q >= {3'b000, PRICE1};
    affordable[2] = credit_q >= {3'b000, PRICE2};
    affordable[3] = credit_q >= {3'b000, PRICE3};
    affordable[4] = credit_q >= {3'b000, PRICE4};
  end

  assign coin_sum = {1'b0, credit_q} + {3'b000, coin_units(coin_value)};

  // Next-state logic: arbitration in IDLE, handshakes elsewhere.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_idx_d      = sel_idx_q;
    dispense_idx_d = dispense_idx_q;
    dispense_req_d = dispense_req_q;
    change_req_d   = change_req_q;
    change_coin_d  = change_coin_q;
    coin_reject_d  = 1'b0;
    buy_denied_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (credit_q != '0) begin
            state_d       = CHANGE;
            change_req_d  = 1'b1;
            change_coin_d = payout_coin(credit_q);
          end
        end else if (buy) begin
          coin_reject_d = coin_valid;
          if (credit_q >= {3'b000, sel_price}) begin
            credit_d       = credit_q - {3'b000, sel_price};
            dispense_idx_d = sel_idx_q;
            dispense_req_d = 1'b1;
            state_d        = VEND;
          end else begin
            buy_denied_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_sum <= {1'b0, MAX_CREDIT}) credit_d = coin_sum[6:0];
          else                                coin_reject_d = 1'b1;
        end else if (sel_right && !sel_left) begin
          sel_idx_d = (sel_idx_q == 3'd4) ? 3'd0 : sel_idx_q + 3'd1;
        end else if (sel_left && !sel_right) begin
          sel_idx_d = (sel_idx_q == 3'd0) ? 3'd4 : sel_idx_q - 3'd1;
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        if (dispense_ack && dispense_req_q) begin
          dispense_req_d = 1'b0;
          state_d        = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ack && change_req_q) begin
          credit_d     = credit_q - {2'b00, coin_units(change_coin_q)};
          change_req_d = 1'b0;
          state_d      = (credit_d == '0) ? IDLE : GAP;
        end
      end
      default: begin
        coin_reject_d = coin_valid;
        state_d       = CHANGE;
        change_req_d  = 1'b1;
        change_coin_d = payout_coin(credit_q);
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      sel_idx_q      <= '0;
      dispense_idx_q <= '0;
      dispense_req_q <= 1'b0;
      change_req_q   <= 1'b0;
      change_coin_q  <= '0;
      coin_reject_q  <= 1'b0;
      buy_denied_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_idx_q      <= sel_idx_d;
      dispense_idx_q <= dispense_idx_d;
      dispense_req_q <= dispense_req_d;
      change_req_q   <= change_req_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      buy_denied_q   <= buy_denied_d;
    end
  end

  assign credit       = credit_q;
  assign sel_idx      = sel_idx_q;
  assign dispense_req = dispense_req_q;
  assign dispense_idx = dispense_idx_q;
  assign change_req   = change_req_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign buy_denied   = buy_denied_q;
  assign busy         = (state_q != IDLE);

endmodule
